// File: rtl/seq_adder_subtractor.sv
// Multi-cycle two's-complement adder/subtractor: one CHUNK-bit slice per clock, LSB first,
// with start/busy/done handshake, signed overflow, zero flag and optional signed saturation.
module seq_adder_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             subt,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sat_q, sat_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] aShift, bShift, workShift, finalSum;
  logic [CHUNK-1:0] aSl, bSl, resSl;
  logic             cSl, cMsbIn, ovfRaw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sat_q   <= sat_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // b_q holds the effective operand (already inverted for subtract); the working
  // register shifts right so the finished slices end up in place after N steps.
  always_comb begin
    aShift    = a_q >> (CHUNK * int'(k_q));
    bShift    = b_q >> (CHUNK * int'(k_q));
    aSl       = aShift[CHUNK-1:0];
    bSl       = bShift[CHUNK-1:0];
    {cSl, resSl} = {1'b0, aSl} + {1'b0, bSl} + {{CHUNK{1'b0}}, carry_q};
    cMsbIn    = resSl[CHUNK-1] ^ aSl[CHUNK-1] ^ bSl[CHUNK-1];
    ovfRaw    = cMsbIn ^ cSl;
    workShift = work_q >> CHUNK;
    finalSum  = workShift | (WIDTH'(resSl) << (WIDTH - CHUNK));
    if (sat_q && ovfRaw) begin
      finalSum = a_q[WIDTH-1] ? MIN_VAL : MAX_VAL;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sat_d   = sat_q;
    carry_d = carry_q;
    k_d     = k_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      RUN: begin
        work_d  = workShift | (WIDTH'(resSl) << (WIDTH - CHUNK));
        carry_d = cSl;
        k_d     = k_q + 1'b1;
        if (k_q == KLAST) begin
          state_d = DONE;
          sum_d   = finalSum;
          cout_d  = cSl;
          ovf_d   = ovfRaw;
          zero_d  = (finalSum == '0);
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = subt ? ~b : b;
          sat_d   = sat;
          carry_d = subt ? ~cin : cin;
          k_d     = '0;
          work_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
